// File: rtl/haraka_pkg.sv
// Shared types and constants for the SHAKE256 absorb/squeeze datapath.
// Squeeze-side state encoding lives next to the sponge constants.
package haraka_pkg;

    localparam int BLOCK_WIDTH  = 256;
    localparam int PACKET_WIDTH = 8;

    // SHAKE256 sponge parameters shared with the absorb-side deserializer
    localparam int         SHAKE256_RATE_BITS  = 1088;
    localparam int         SHAKE256_RATE_BYTES = SHAKE256_RATE_BITS / 8;
    localparam logic [7:0] SHAKE256_PAD_FIRST  = 8'h1F;
    localparam logic [7:0] SHAKE256_PAD_LAST   = 8'h80;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BLOCK,
        SHIFT,
        DONE
    } sq_state_e;

endpackage

// File: rtl/squeeze_serializer.sv
// SHAKE256 squeeze output stage: splits 256-bit blocks into bytes, LSB first,
// stops after out_len bytes and requests further blocks as needed.
module squeeze_serializer
    import haraka_pkg::*;
#(
    parameter int IN_WIDTH             = BLOCK_WIDTH,
    parameter int OUT_WIDTH            = PACKET_WIDTH,
    parameter int PACKETS_IN_BLOCK     = IN_WIDTH / OUT_WIDTH,
    parameter int PACKET_COUNTER_WIDTH = $clog2(PACKETS_IN_BLOCK),
    parameter int LEN_WIDTH            = 16
) (
    input  logic                 clk,
    input  logic                 clear_n,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] out_len,
    input  logic [IN_WIDTH-1:0]  block_in,
    input  logic                 block_valid,
    output logic                 block_ready,
    output logic [OUT_WIDTH-1:0] serial_out,
    output logic                 serial_valid,
    input  logic                 serial_ready,
    output logic                 squeeze_req,
    output logic                 done
);

    localparam logic [PACKET_COUNTER_WIDTH-1:0] LAST_PKT =
        PACKET_COUNTER_WIDTH'(PACKETS_IN_BLOCK - 1);

    sq_state_e                     state_q, state_d;
    logic [IN_WIDTH-1:0]           shreg_q, shreg_d;
    logic [PACKET_COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0]          rem_q, rem_d;
    logic                          sq_req_q, sq_req_d;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            rem_q    <= '0;
            sq_req_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            sq_req_q <= sq_req_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        sq_req_d = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    if (out_len != '0) begin
                        rem_d   = out_len;
                        state_d = WAIT_BLOCK;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            WAIT_BLOCK: begin
                if (block_valid) begin
                    shreg_d = block_in;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (serial_ready) begin
                    shreg_d = shreg_q >> OUT_WIDTH;
                    cnt_d   = cnt_q + 1'b1;
                    if (rem_q != '0) rem_d = rem_q - 1'b1;
                    // Last owed byte ends the run even mid-block; the rest is dropped
                    if (rem_q <= LEN_WIDTH'(1)) begin
                        state_d = DONE;
                    end else if (cnt_q == LAST_PKT) begin
                        state_d  = WAIT_BLOCK;
                        sq_req_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign block_ready  = (state_q == WAIT_BLOCK);
    assign serial_valid = (state_q == SHIFT);
    assign serial_out   = serial_valid ? shreg_q[OUT_WIDTH-1:0] : '0;
    assign squeeze_req  = sq_req_q;
    assign done         = (state_q == DONE);

endmodule

// File: tb/tb_squeeze_serializer.sv
// Directed bench for squeeze_serializer with a byte scoreboard and a
// negedge monitor that also records handshake/accept/done timing.
module tb_squeeze_serializer;

    logic         clk = 1'b0;
    logic         clear_n;
    logic         start;
    logic [15:0]  out_len;
    logic [255:0] block_in;
    logic         block_valid;
    logic         block_ready;
    logic [7:0]   serial_out;
    logic         serial_valid;
    logic         serial_ready;
    logic         squeeze_req;
    logic         done;

    squeeze_serializer dut (
        .clk          (clk),
        .clear_n      (clear_n),
        .start        (start),
        .out_len      (out_len),
        .block_in     (block_in),
        .block_valid  (block_valid),
        .block_ready  (block_ready),
        .serial_out   (serial_out),
        .serial_valid (serial_valid),
        .serial_ready (serial_ready),
        .squeeze_req  (squeeze_req),
        .done         (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0]   sb[$];
    logic [255:0] bq[$];

    int cyc = 0;
    int start_cyc = 0;
    int acc_n, acc1, acc2, hs_n, first_cyc, last_cyc, hs32_cyc;
    int sq_n, sq_cyc, done_cyc, br_seen, sv_seen;
    bit tog_en = 1'b0;
    bit hold_pend = 1'b0;
    logic [7:0] hold_byte;

    task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] mk_block(input logic [7:0] base);
        logic [255:0] b;
        for (int i = 0; i < 32; i++) b[i*8 +: 8] = base + 8'(i);
        return b;
    endfunction

    task automatic push_bytes(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) sb.push_back(base + 8'(i));
    endtask

    // Monitor: everything sampled on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (clear_n) begin
                if (block_valid && block_ready) begin
                    acc_n++;
                    if (acc_n == 1) acc1 = cyc;
                    else if (acc_n == 2) acc2 = cyc;
                end
                if (block_ready) br_seen++;
                if (serial_valid) sv_seen++;
                if (squeeze_req) begin
                    sq_n++;
                    sq_cyc = cyc;
                end
                if (done && done_cyc < 0 && cyc > start_cyc + 1) done_cyc = cyc;
                if (hold_pend)
                    chk(serial_valid && serial_out == hold_byte, "hold_stable",
                        {serial_valid, serial_out}, {1'b1, hold_byte});
                hold_pend = serial_valid && !serial_ready;
                hold_byte = serial_out;
                if (serial_valid && serial_ready) begin
                    hs_n++;
                    if (first_cyc < 0) first_cyc = cyc;
                    last_cyc = cyc;
                    if (hs_n == 32) hs32_cyc = cyc;
                    if (sb.size() == 0) begin
                        chk(1'b0, "sb_underflow", serial_out, -1);
                    end else begin
                        logic [7:0] e;
                        e = sb.pop_front();
                        chk(serial_out == e, "byte", serial_out, e);
                    end
                end
            end else begin
                hold_pend = 1'b0;
            end
        end
    end

    // Upstream block source: holds block_valid until accepted
    initial begin
        bit facc;
        block_valid = 1'b0;
        block_in    = '0;
        forever begin
            @(negedge clk);
            facc = block_valid && block_ready && clear_n;
            @(posedge clk);
            #1;
            if (facc && bq.size() > 0) void'(bq.pop_front());
            block_valid = (bq.size() > 0);
            block_in    = block_valid ? bq[0] : '0;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tog_en) serial_ready = ~serial_ready;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clr_stats();
        acc_n = 0; acc1 = -1; acc2 = -1; hs_n = 0; first_cyc = -1; last_cyc = -1;
        hs32_cyc = -1; sq_n = 0; sq_cyc = -1; done_cyc = -1; br_seen = 0; sv_seen = 0;
    endtask

    task automatic do_start(input logic [15:0] len);
        clr_stats();
        start_cyc = cyc;
        start   = 1'b1;
        out_len = len;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int maxc, input string nm);
        for (int i = 0; i < maxc && done_cyc < 0; i++) tick();
        if (done_cyc < 0) chk(1'b0, nm, 0, 1);
    endtask

    task automatic wait_hs(input int n, input int maxc);
        for (int i = 0; i < maxc && hs_n < n; i++) tick();
        if (hs_n < n) chk(1'b0, "hs_timeout", hs_n, n);
    endtask

    task automatic chk_single_block(input string tag);
        chk(first_cyc == acc1 + 1, {tag, "_latency"}, first_cyc - acc1, 1);
        chk(last_cyc == first_cyc + 31, {tag, "_burst"}, last_cyc - first_cyc, 31);
        chk(done_cyc == last_cyc + 1, {tag, "_done_time"}, done_cyc - last_cyc, 1);
        chk(hs_n == 32, {tag, "_count"}, hs_n, 32);
        chk(sq_n == 0, {tag, "_no_sqreq"}, sq_n, 0);
        chk(acc_n == 1, {tag, "_accepts"}, acc_n, 1);
        chk(sb.size() == 0, {tag, "_sb_empty"}, sb.size(), 0);
    endtask

    initial begin
        clr_stats();
        clear_n = 1'b0; start = 1'b0; out_len = '0; serial_ready = 1'b1;
        #23;
        chk({block_ready, serial_valid, serial_out, squeeze_req, done} == '0,
            "reset_outputs", {block_ready, serial_valid, serial_out, squeeze_req, done}, 0);
        tick();
        clear_n = 1'b1;
        tick(); tick();

        // Zero length from IDLE
        chk(done == 1'b0, "zl_done_before", done, 0);
        do_start(16'd0);
        wait_done(5, "zl_done_timeout");
        chk(done_cyc == start_cyc + 2, "zl_done_time", done_cyc - start_cyc, 2);
        repeat (4) tick();
        chk(done == 1'b1, "zl_done_held", done, 1);
        chk(br_seen == 0, "zl_no_block_ready", br_seen, 0);
        chk(sv_seen == 0, "zl_no_serial_valid", sv_seen, 0);

        // Single block
        push_bytes(8'h00, 32);
        bq.push_back(mk_block(8'h00));
        do_start(16'd32);
        wait_done(100, "t1_done_timeout");
        chk_single_block("t1");
        tick();

        // Two blocks, second one truncated after 8 bytes
        push_bytes(8'h00, 32);
        push_bytes(8'h80, 8);
        bq.push_back(mk_block(8'h00));
        bq.push_back(mk_block(8'h80));
        do_start(16'd40);
        wait_done(150, "t2_done_timeout");
        chk(hs_n == 40, "t2_count", hs_n, 40);
        chk(sq_n == 1, "t2_sqreq_count", sq_n, 1);
        chk(sq_cyc == hs32_cyc + 1, "t2_sqreq_time", sq_cyc - hs32_cyc, 1);
        chk(acc_n == 2, "t2_accepts", acc_n, 2);
        chk(acc2 == hs32_cyc + 1, "t2_b_accept", acc2 - hs32_cyc, 1);
        chk(last_cyc == acc2 + 8, "t2_b_burst", last_cyc - acc2, 8);
        chk(done_cyc == last_cyc + 1, "t2_done_time", done_cyc - last_cyc, 1);
        chk(sb.size() == 0, "t2_sb_empty", sb.size(), 0);
        tick();

        // Backpressure with alternating ready
        push_bytes(8'h00, 8);
        bq.push_back(mk_block(8'h00));
        tog_en = 1'b1;
        do_start(16'd8);
        wait_done(100, "t3_done_timeout");
        tog_en = 1'b0;
        serial_ready = 1'b1;
        chk(hs_n == 8, "t3_count", hs_n, 8);
        chk(last_cyc - first_cyc == 14, "t3_span", last_cyc - first_cyc, 14);
        chk(done_cyc == last_cyc + 1, "t3_done_time", done_cyc - last_cyc, 1);
        chk(sb.size() == 0, "t3_sb_empty", sb.size(), 0);
        tick();

        // Reset mid-run after byte 0x09
        push_bytes(8'h00, 32);
        bq.push_back(mk_block(8'h00));
        do_start(16'd32);
        wait_hs(10, 100);
        clear_n = 1'b0;
        sb.delete();
        bq.delete();
        #1;
        chk({block_ready, serial_valid, serial_out, squeeze_req, done} == '0,
            "t5_reset_outputs", {block_ready, serial_valid, serial_out, squeeze_req, done}, 0);
        repeat (3) tick();
        clear_n = 1'b1;
        chk(sq_n == 0, "t5_no_sqreq", sq_n, 0);
        chk(done_cyc < 0, "t5_no_partial_done", done_cyc, -1);
        tick();
        push_bytes(8'h50, 4);
        bq.push_back(mk_block(8'h50));
        do_start(16'd4);
        wait_done(50, "t5_done_timeout");
        chk(hs_n == 4, "t5_count", hs_n, 4);
        chk(first_cyc == acc1 + 1, "t5_latency", first_cyc - acc1, 1);
        chk(done_cyc == last_cyc + 1, "t5_done_time", done_cyc - last_cyc, 1);
        chk(sb.size() == 0, "t5_sb_empty", sb.size(), 0);
        tick();

        // Stray start and block_valid during SHIFT
        push_bytes(8'h00, 32);
        bq.push_back(mk_block(8'h00));
        do_start(16'd32);
        wait_hs(5, 50);
        start   = 1'b1;
        out_len = 16'd3;
        bq.push_back(mk_block(8'hC0));
        tick();
        start = 1'b0;
        wait_done(100, "t6_done_timeout");
        chk_single_block("t6");
        bq.delete();
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d expected=0", cyc);
        $fatal(1, "timeout");
    end

endmodule
